// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues synchronous ROM reads and
// queues returned instructions in a show-ahead prefetch FIFO with valid/ready output.
module inst_fetch_unit #(
    parameter int                 DEPTH    = 4,
    parameter int                 ADDR_W   = 8,
    parameter int                 INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic               rom_rd_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    entry_t            mem_q [DEPTH];

    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;
    entry_t            head;

    // Issue only when the queue can absorb every read already committed to it,
    // so a response can never arrive into a full FIFO.
    always_comb begin
        occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        issue     = rst_n & fetch_en & ~redirect & (occupancy < (CNT_W + 1)'(DEPTH));
        push      = inflight_q & ~redirect;
        pop       = (count_q != '0) & instr_ready & ~redirect;
    end

    // NOTE: every next-state signal gets its default (hold) first so no path
    // through this block leaves one unassigned and infers a latch.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
                issued_pc_d = fetch_pc_q;
                inflight_d  = 1'b1;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are
    // meaningful, and the outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_t'{instr: rom_data, pc: issued_pc_q};
    end

    always_comb begin
        head        = mem_q[rd_ptr_q];
        instr_valid = (count_q != '0);
        instr       = instr_valid ? head.instr : '0;
        instr_pc    = instr_valid ? head.pc : '0;
        rom_rd_en   = issue;
        rom_addr    = fetch_pc_q;
    end

endmodule
